// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch/PC stage: widths, reset PC, opcodes and FSM encoding.
package fetch_pc_unit_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned JIDX_W     = 26;

  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2
  } fetch_state_e;

  // beq/bne resolution; both set means taken if either condition holds
  function automatic logic branch_taken(input logic branch, input logic bne,
                                        input logic alu_zero);
    return (branch & alu_zero) | (bne & ~alu_zero);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// Combinational next-PC resolution: jump, then taken branch, then sequential.
module fetch_pc_unit_next_pc_calc
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc_plus4_i,
  input  logic [JIDX_W-1:0] instr_i,
  input  logic              branch_i,
  input  logic              bne_i,
  input  logic              jump_i,
  input  logic              alu_zero_i,
  output logic [ADDR_W-1:0] next_pc_c
);

  logic [ADDR_W-1:0] br_off;
  logic              taken;

  always_comb begin
    br_off    = {{(ADDR_W-IMM_W-2){instr_i[IMM_W-1]}}, instr_i[IMM_W-1:0], 2'b00};
    taken     = branch_taken(branch_i, bne_i, alu_zero_i);
    next_pc_c = pc_plus4_i;
    // jump wins: the decoder leaves branch undefined on j
    if (jump_i) begin
      next_pc_c = {pc_plus4_i[ADDR_W-1:28], instr_i, 2'b00};
    end else if (taken) begin
      next_pc_c = pc_plus4_i + br_off;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register, fetch handshake FSM and retired-instruction counter feeding decode.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int unsigned      ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_plus4,
  input  logic               stall,
  input  logic               branch,
  input  logic               bne,
  input  logic               jump,
  input  logic               alu_zero,
  output logic [CNT_W-1:0]   retired_cnt
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_INC      = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pc_plus4_q, pc_plus4_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  next_pc_c;

  fetch_pc_unit_next_pc_calc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .pc_plus4_i (pc_plus4_q),
    .instr_i    (instr_q[JIDX_W-1:0]),
    .branch_i   (branch),
    .bne_i      (bne),
    .jump_i     (jump),
    .alu_zero_i (alu_zero),
    .next_pc_c  (next_pc_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC_AL;
      pc_plus4_q <= RESET_PC_AL + PC_INC;
      instr_q    <= '0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic; req/valid are registered Moore decodes of the next state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall) begin
          pc_d    = next_pc_c & ALIGN_MASK;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pc_plus4_d = pc_d + PC_INC;
    req_d      = (state_d == ST_REQ);
    valid_d    = (state_d == ST_EXEC);
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_plus4    = pc_plus4_q;
  assign retired_cnt = cnt_q;

endmodule
